sdram_read: RTL

SDRAM_READ -- requirements
Module: sdram_read

---
 rtl/sdram_read.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/sdram_read.sv
// SDRAM read controller: ACTIVE, full-page READ stopped by BURST_TERM, PRECHARGE all, done.
// Define SDRAM_RD_DQ_REG_EN to register rd_data (adds one cycle of read latency).
module sdram_read #(
  parameter int unsigned TRCD_CLK = 2,
  parameter int unsigned TCL_CLK  = 3,
  parameter int unsigned TRP_CLK  = 2
) (
  input  logic        rd_clk,
  input  logic        rd_rst,
  input  logic        init_end,
  input  logic        rd_en,
  input  logic [23:0] rd_addr,
  input  logic [9:0]  rd_bst_len,
  input  logic [15:0] rd_sdram_data,
  output logic        rd_ack,
  output logic        rd_end,
  output logic [3:0]  rd_sdram_cmd,
  output logic [1:0]  rd_sdram_bank,
  output logic [12:0] rd_sdram_addr,
  output logic [15:0] rd_data
);

  localparam logic [3:0] CmdNop       = 4'b0111;
  localparam logic [3:0] CmdActive    = 4'b0011;
  localparam logic [3:0] CmdRead      = 4'b0101;
  localparam logic [3:0] CmdBurstTerm = 4'b0110;
  localparam logic [3:0] CmdPrecharge = 4'b0010;

  // Cycles spent in StTcl; the DQ register moves the data window one cycle later.
`ifdef SDRAM_RD_DQ_REG_EN
  localparam int unsigned TclLen = TCL_CLK;
`else
  localparam int unsigned TclLen = TCL_CLK - 1;
`endif

  localparam logic [9:0] TrcdLast = 10'(TRCD_CLK - 1);
  localparam logic [9:0] TclLast  = 10'(TclLen - 1);
  localparam logic [9:0] TrpLast  = 10'(TRP_CLK - 1);
  localparam logic [9:0] TclLenW  = 10'(TclLen);

  typedef enum logic [3:0] {
    StIdle = 4'b0000,
    StAct  = 4'b0001,
    StTrcd = 4'b0011,
    StRd   = 4'b0010,
    StTcl  = 4'b0100,
    StData = 4'b0101,
    StPre  = 4'b0111,
    StTrp  = 4'b0110,
    StEnd  = 4'b1100
  } state_e;

  state_e      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [23:0] addr_q;
  logic [9:0]  len_q;
  logic [9:0]  len_eff;
  logic        start;
  logic        bst_hit;

  assign start = (state_q == StIdle) && init_end && rd_en;

  always_comb begin
    if (rd_bst_len == 10'd0) begin
      len_eff = 10'd1;
    end else if (rd_bst_len > 10'd512) begin
      len_eff = 10'd512;
    end else begin
      len_eff = rd_bst_len;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StAct;
      StAct:   state_d = StTrcd;
      StTrcd:  if (cnt_q == TrcdLast) state_d = StRd;
      StRd:    state_d = StTcl;
      StTcl:   if (cnt_q == TclLast) state_d = StData;
      StData:  if (cnt_q == len_q - 10'd1) state_d = StPre;
      StPre:   state_d = StTrp;
      StTrp:   if (cnt_q == TrpLast) state_d = StEnd;
      StEnd:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign cnt_d = (state_d != state_q) ? 10'd0 : cnt_q + 10'd1;

  // BURST_TERM lands L cycles after READ; short bursts hit it while still in StTcl.
  always_comb begin
    bst_hit = 1'b0;
    if (state_q == StTcl && len_q <= TclLenW && cnt_q == len_q - 10'd1) begin
      bst_hit = 1'b1;
    end
    if (state_q == StData && len_q > TclLenW && cnt_q == len_q - TclLenW - 10'd1) begin
      bst_hit = 1'b1;
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_q <= StIdle;
      cnt_q   <= 10'd0;
      addr_q  <= 24'd0;
      len_q   <= 10'd1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (start) begin
        addr_q <= rd_addr;
        len_q  <= len_eff;
      end
    end
  end

  always_comb begin
    rd_sdram_cmd  = CmdNop;
    rd_sdram_bank = 2'b11;
    rd_sdram_addr = 13'h1FFF;
    rd_ack        = 1'b0;
    rd_end        = 1'b0;
    case (state_q)
      StAct: begin
        rd_sdram_cmd  = CmdActive;
        rd_sdram_bank = addr_q[23:22];
        rd_sdram_addr = addr_q[21:9];
      end
      StRd: begin
        rd_sdram_cmd  = CmdRead;
        rd_sdram_bank = addr_q[23:22];
        rd_sdram_addr = {4'b0000, addr_q[8:0]};
      end
      StTcl: begin
        if (bst_hit) rd_sdram_cmd = CmdBurstTerm;
      end
      StData: begin
        rd_ack = 1'b1;
        if (bst_hit) rd_sdram_cmd = CmdBurstTerm;
      end
      StPre: begin
        rd_sdram_cmd  = CmdPrecharge;
        rd_sdram_bank = addr_q[23:22];
        rd_sdram_addr = 13'h0400;
      end
      StEnd:   rd_end = 1'b1;
      default: ;
    endcase
  end

`ifdef SDRAM_RD_DQ_REG_EN
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      rd_data <= 16'd0;
    end else begin
      rd_data <= rd_sdram_data;
    end
  end
`else
  assign rd_data = rd_sdram_data;
`endif

endmodule
